// File: rtl/latch_bank_write_arbiter.sv
// Round-robin arbiter owning the D/E inputs of a shared D-latch bank.
// Each write runs a fixed window: data setup, EN_CYCLES of enable, data hold,
// then a one-cycle done pulse back to the granted requester.
module latch_bank_write_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 8,
   parameter int unsigned EN_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]    grant,
   output logic               done,
   output logic               busy,
   output logic [DW-1:0]      latch_d,
   output logic               latch_e
);

   localparam int unsigned PW = (NREQ > 2) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ENABLE = 3'd2,
      HOLD   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] winner;
   logic [CW-1:0] cnt;
   logic [DW-1:0] data;
   logic [PW-1:0] pick_c;
   logic          found_c;
   int unsigned   sum;

   // First set request at or after ptr, wrapping modulo NREQ
   always_comb begin
      found_c = 1'b0;
      pick_c  = '0;
      sum     = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         sum = 32'(ptr) + i;
         if (sum >= NREQ) sum = sum - NREQ;
         if (!found_c && req[PW'(sum)]) begin
            found_c = 1'b1;
            pick_c  = PW'(sum);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found_c) state_nxt = SETUP;
         SETUP:   state_nxt = ENABLE;
         ENABLE:  if (cnt == CW'(EN_CYCLES - 1)) state_nxt = HOLD;
         HOLD:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Arbitration capture: data frozen, winner recorded, pointer advanced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         winner <= '0;
         data   <= '0;
      end else if (state == IDLE && found_c) begin
         data   <= wdata[32'(pick_c)*DW +: DW];
         winner <= pick_c;
         ptr    <= (pick_c == PW'(NREQ - 1)) ? '0 : pick_c + PW'(1);
      end
   end

   // Enable-phase cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == ENABLE) begin
         cnt <= (cnt == CW'(EN_CYCLES - 1)) ? '0 : cnt + CW'(1);
      end else begin
         cnt <= '0;
      end
   end

   // Registered outputs decoded from the current state; latch_d only moves in SETUP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant   <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         latch_e <= 1'b0;
         latch_d <= '0;
      end else begin
         busy    <= (state != IDLE);
         grant   <= (state != IDLE) ? (NREQ'(1) << winner) : '0;
         latch_e <= (state == ENABLE);
         done    <= (state == DONE);
         if (state == SETUP) latch_d <= data;
      end
   end

endmodule

// File: doc/latch_bank_write_arbiter.md
Name: latch_bank_write_arbiter

Overview:
- Round-robin arbiter that shares one DW-bit bank of level-sensitive D latches among NREQ requesters.
- Sequences every latch write with a fixed timing window: data setup, then enable pulse, then data hold. This keeps D stable for the whole time latch E is high and across its falling edge.
- Sits between the requesting logic and the D_Latch bank. It is the only driver of the bank's D and E inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, latch bank data width.
- EN_CYCLES, 2, clock cycles latch_e is held high per write (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester write request, level, held until done.
- wdata  in  NREQ*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
- grant  out  NREQ  one-hot owner of the current write; all zero when idle.
- done  out  1  one-cycle pulse marking write completion to the granted requester.
- busy  out  1  high whenever the FSM is not in IDLE.
- latch_d  out  DW  D input to the latch bank.
- latch_e  out  1  E input to the latch bank.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - grant=0, done=0, busy=0, latch_e=0, latch_d=0.
  - Round-robin pointer ptr=0, enable counter=0.
  - Deassertion is synchronous to clk, with no special handling.
- All outputs are registered. There are no combinational paths from req or wdata to any output.
- FSM states: IDLE, SETUP, ENABLE, HOLD, DONE.
- IDLE:
  - If req!=0, select the first set req bit searching from index ptr upward, wrapping modulo NREQ.
  - Capture that requester's wdata slice into the internal data register.
  - Set ptr=(winner+1) mod NREQ.
  - Go to SETUP.
  - If req==0, stay in IDLE with all outputs unchanged.
- SETUP (1 cycle): latch_d=captured data, latch_e=0, grant=one-hot winner, busy=1.
- ENABLE (EN_CYCLES cycles): latch_e=1, latch_d stable. The counter counts 0..EN_CYCLES-1, then the FSM goes to HOLD.
- HOLD (1 cycle): latch_e=0, latch_d still stable.
- DONE (1 cycle):
  - done=1, grant still asserted, latch_e=0.
  - Next state is IDLE, where grant=0, done=0, busy=0.
- Timing:
  - If req is sampled in IDLE at edge N, SETUP is visible after edge N+1.
  - latch_e is high for exactly EN_CYCLES cycles.
  - done is high during cycle 3+EN_CYCLES counted from the decision edge.
  - Minimum spacing between two writes is one IDLE cycle.
- latch_d keeps its last written value in IDLE; it is only ever changed in SETUP.
- latch_e never rises in the same cycle that latch_d changes, and never falls in a cycle where latch_d changes.
- The captured data is frozen at the arbitration edge. wdata or req changes after that have no effect on the transaction in flight.
- A requester dropping req mid-transaction does not abort it; the write completes and done is pulsed.
- A req still high in the IDLE cycle after DONE counts as a new request. It is arbitrated behind other pending requesters because ptr has already advanced.
- Only one grant is active at a time; grant is always one-hot or zero.
- Pointer wrap: winner NREQ-1 sets ptr=0.
- Reset asserted mid-write:
  - latch_e drops immediately (asynchronously) and latch_d clears to 0.
  - No done pulse is issued.
  - The latch content is undefined and must be rewritten by software.

Test Plan:
- Single request, EN_CYCLES=2: after reset, req=4'b0010 and wdata slice1=8'hA5 for one edge, then held. Required: SETUP 1 cycle with latch_d=A5, latch_e=0, grant=0010; latch_e=1 for exactly 2 cycles; HOLD with latch_e=0; done pulse for 1 cycle in cycle 5 after the decision edge; then grant=0, busy=0, latch_d stays A5.
- Round-robin fairness: req=4'b1111 held, slices 11/22/33/44, requester i drops req on its done. Required: grants in order 0001, 0010, 0100, 1000, and latch_d sequence 11, 22, 33, 44.
- Pointer wrap and re-request: grant to requester 3, then req=1001 held continuously. Required: next grant is 0001 (ptr=0) and the following grant is 1000.
- Data freeze: change wdata slice0 from 5A to C3 during ENABLE. Required: latch_d=5A throughout, and C3 is written only by a later request.
- Reset mid-ENABLE: pull rst_n low while latch_e=1. Required: in the same cycle, with no clock edge needed, latch_e=0, latch_d=0, grant=0, busy=0, and no done. After release with req still high, a fresh arbitration starts from ptr=0.
- Setup/hold invariant over 500 random req/wdata cycles: latch_d never changes while latch_e=1 or in the cycle where latch_e falls, and grant is always one-hot or zero.
